// File: rtl/dct_mac_descale.sv
// dct_mac_descale
//
// Sums TAPS consecutive signed products from the DCT multiplier into one
// coefficient. Each finished sum is rounded half-up and arithmetically
// shifted right by SHIFT, then saturated to OUT_WIDTH signed bits. The
// result is held in a single output register.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid_i   in_data_i holds a valid product
//   in_ready_o   block accepts in_data_i this cycle
//   in_data_i    signed product, PROD_WIDTH bits
//   out_valid_o  out_data_o holds a valid coefficient
//   out_ready_i  downstream accepts out_data_o this cycle
//   out_data_o   signed descaled, saturated coefficient, OUT_WIDTH bits
//   busy_o       a row is partially accumulated (tap count != 0)
//
// Only the tap that completes a row is blocked while the output register is
// stalled. The next row can therefore accumulate up to TAPS-1 taps behind a
// pending result.

module dct_mac_descale #(
    parameter int unsigned TAPS       = 8,
    parameter int unsigned PROD_WIDTH = 29,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned SHIFT      = 13,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PROD_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  busy_o
);

    localparam int unsigned CntW = $clog2(TAPS);
    localparam logic [CntW-1:0] LastTap = CntW'(TAPS - 1);
    // Rounding bias, one half of the descale LSB.
    localparam logic [ACC_WIDTH:0] HalfLsb = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CntW-1:0]             count_q, count_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                        last_tap;
    logic                        accept;
    logic                        load_out;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   sum_x;
    logic signed [ACC_WIDTH:0]   biased_x;
    logic signed [ACC_WIDTH:0]   rnd_x;
    logic [ACC_WIDTH:OUT_WIDTH-1] rnd_upper;
    logic                        rnd_fits;
    logic [OUT_WIDTH-1:0]        sat_val;

    assign last_tap = (count_q == LastTap);

    // Depends only on the output state and tap count, never on in_valid_i.
    assign in_ready_o = !(out_valid_q && !out_ready_i && last_tap);

    assign accept   = in_valid_i && in_ready_o;
    assign load_out = accept && last_tap;

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_data_i[PROD_WIDTH-1]}}, in_data_i};

    // Tap zero starts a fresh sum, so any stale accumulator value is ignored.
    assign acc_base = (count_q == '0) ? '0 : acc_q;
    assign sum      = acc_base + prod_ext;

    // One extra bit of headroom keeps the rounding add from overflowing.
    assign sum_x    = {sum[ACC_WIDTH-1], sum};
    assign biased_x = sum_x + $signed(HalfLsb);
    assign rnd_x    = biased_x >>> SHIFT;

    // The result fits when every bit above the output sign bit copies it.
    assign rnd_upper = rnd_x[ACC_WIDTH:OUT_WIDTH-1];
    assign rnd_fits  = (&rnd_upper) || !(|rnd_upper);

    always_comb begin
        sat_val = rnd_x[OUT_WIDTH-1:0];
        if (!rnd_fits) begin
            if (rnd_x[ACC_WIDTH]) begin
                sat_val = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            end else begin
                sat_val = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        if (accept) begin
            acc_d = sum;
            if (last_tap) begin
                count_d = '0;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    // A new result takes priority over a drain in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_val;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (count_q != '0);

endmodule

// File: tb/tb_dct_mac_descale.sv
module tb_dct_mac_descale;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    dct_mac_descale #(
        .TAPS      (8),
        .PROD_WIDTH(29),
        .ACC_WIDTH (32),
        .SHIFT     (13),
        .OUT_WIDTH (16)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int odata();
        return int'($signed(out_data));
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = 29'(d);
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full row: first product d0, then seven copies of d_rest.
    task automatic row(input string tag, input int d0, input int d_rest, input int exp);
        push(d0);
        for (int i = 1; i < 8; i++) push(d_rest);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, odata(), exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", odata(), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Basic row: latency and single-cycle pulse.
        for (int i = 0; i < 7; i++) push(8192);
        check("basic_busy_mid", int'(busy), 1);
        check("basic_no_early_valid", int'(out_valid), 0);
        push(8192);
        check("basic_valid", int'(out_valid), 1);
        check("basic_data", odata(), 8);
        check("basic_busy_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("basic_pulse_end", int'(out_valid), 0);

        // Rounding and saturation.
        row("round_pos_half", 4096, 0, 1);
        row("round_neg_half", -4096, 0, 0);
        row("round_neg_more", -4097, 0, -1);
        row("sat_pos", 268435455, 268435455, 32767);
        row("sat_neg", -268435456, -268435456, -32768);

        // Backpressure: A = 8 stalls, B = 16 completes on the drain cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8192);
        check("bp_a_valid", int'(out_valid), 1);
        for (int i = 0; i < 7; i++) push(16384);
        check("bp_b_busy", int'(busy), 1);
        check("bp_in_ready_blocked", int'(in_ready), 0);
        check("bp_a_held", odata(), 8);
        in_valid = 1'b1;
        in_data  = 29'(16384);
        @(posedge clk);
        #1;
        check("bp_a_still_held", odata(), 8);
        check("bp_a_still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_released", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b_valid_cont", int'(out_valid), 1);
        check("bp_b_data", odata(), 16);
        check("bp_b_busy_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("bp_drained", int'(out_valid), 0);

        // Bubbles between every tap.
        for (int i = 0; i < 8; i++) begin
            push(1000);
            if (i == 0) check("bub_busy_first", int'(busy), 1);
            if (i < 7) begin
                check("bub_no_valid", int'(out_valid), 0);
                @(posedge clk);
                #1;
                check("bub_busy_gap", int'(busy), 1);
            end
        end
        check("bub_valid", int'(out_valid), 1);
        check("bub_data", odata(), 1);
        check("bub_busy_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("bub_single", int'(out_valid), 0);

        // Reset mid-row drops the partial sum.
        for (int i = 0; i < 3; i++) push(1048576);
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        push(8192);
        check("mid_after_valid", int'(out_valid), 0);
        for (int i = 1; i < 8; i++) push(8192);
        check("mid_out_valid", int'(out_valid), 1);
        check("mid_out_data", odata(), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
